alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Two-requester scheduler for the shared 16-bit ALU (divide, multiply, sub, add, or, and, xor).
//  Arbitrates requests round-robin and holds opcode/operands stable on the ALU inputs.
//  Pulses bgn for multi-cycle ops and times each op with a per-class cycle counter.
//  Returns the 32-bit result and flags to the granted requester over valid/ready handshakes.
// PARAMETERS
//  DIV_CYCLES  20  clocks from bgn pulse until divide result is valid on alu_outbus (op 0)
//  MUL_CYCLES  20  clocks from bgn pulse until multiply result is valid (op 1)
//  ALU_CYCLES  2   clocks for single-cycle ops 2..6 (input settle + ALU output register)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  req_valid    in   2   per-requester request valid; index 0 = requester A, 1 = B
//  req_ready    out  2   one-hot; request accepted on the cycle req_valid[i] & req_ready[i]
//  req_op       in   8   {op_B, op_A}: 4-bit ALU control code per requester
//  req_a        in   32  {a_B, a_A}: 16-bit operand nr1 per requester
//  req_b        in   32  {b_B, b_A}: 16-bit operand nr2 per requester
//  rsp_valid    out  1   response valid
//  rsp_ready    in   1   response consumed when rsp_valid & rsp_ready
//  rsp_id       out  1   requester that owns the response
//  rsp_data     out  32  result: full 32 bits for ops 0/1, zero-extended 16 bits otherwise
//  rsp_carry    out  1   carry-out (op 3 only, else 0)
//  rsp_borrow   out  1   borrow-out (op 2 only, else 0)
//  rsp_err      out  1   illegal opcode (7..15); rsp_data = 0
//  alu_bgn      out  1   one-cycle start pulse to the ALU
//  alu_control  out  4   ALU opcode, held for the whole op
//  alu_nr1      out  16  ALU operand 1, held
//  alu_nr2      out  16  ALU operand 2, held
//  alu_outbus   in   32  ALU result
//  alu_carry    in   1   ALU carry_next
//  alu_borrow   in   1   ALU borrow_next
// BEHAVIOUR
//  Reset (async): state IDLE; rr pointer -> A; all outputs 0 (req_ready, rsp_*, alu_*).
//  FSM states: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
//   IDLE : req_ready combinational, one-hot to the winner; winner = the only valid requester,
//          or the rr-pointer side if both are valid. On accept, latch id/op/a/b and go to ISSUE.
//          If no request is valid, req_ready = 0.
//   ISSUE: drive alu_control/nr1/nr2 from the latches.
//          - op 0/1: alu_bgn = 1 for this cycle only; cnt <= DIV/MUL_CYCLES-1.
//          - op 2..6: cnt <= ALU_CYCLES-1.
//          - op >= 7: skip BUSY and go to RESP with rsp_err = 1; ALU is not started.
//   BUSY : cnt decrements each clock. At cnt == 0, capture alu_outbus and flags into the
//          rsp registers, then go to RESP.
//          Mask flags: carry kept only for op 3, borrow only for op 2.
//   RESP : rsp_valid = 1; rsp_* held stable until rsp_ready. On handshake, flip rr pointer
//          to the non-served requester and go to IDLE. Earliest next accept is the cycle after.
//  ALU inputs hold the last issued values outside an op; bgn is never asserted outside ISSUE.
//  Throughput: at most one op in flight.
//   - single-cycle op, rsp_ready tied high: accept-to-rsp_valid = 1+ALU_CYCLES clocks.
//   - multi-cycle op: 1+DIV/MUL_CYCLES clocks.
//  Back-pressure: a held rsp_valid blocks new grants; req_ready stays 0 outside IDLE.
//  A requester dropping req_valid before accept is legal; it simply loses arbitration.
//  rst mid-op: abort immediately with no response emitted. The ALU's internal sequencers get
//  rst directly and restart cleanly; the next op needs a fresh bgn.
//  Counter width: $clog2(max(DIV_CYCLES,MUL_CYCLES,ALU_CYCLES))+1. Parameters must be >= 1.
// STRUCTURE
//  Shared package alu_pkg holds:
//   - opcode constants OP_DIV=0, OP_MUL=1, OP_SUB=2, OP_ADD=3, OP_OR=4, OP_AND=5, OP_XOR=6
//   - FSM state encodings
//   - default cycle counts
//  One sub-module rr_arb2 (2-way round-robin grant with pointer update on a done strobe).
//  The rest is flat: FSM, latches, counter.
// TESTING
//  1. Reset: hold rst, then drive req_valid=2'b11 -> all outputs 0.
//     Release rst -> grant A first (req_ready=2'b01).
//  2. A: op 3, a=16'hFFFF, b=16'h0001 -> rsp_data=32'h0000_0000, rsp_carry=1, rsp_id=0,
//     rsp_valid exactly 1+ALU_CYCLES clocks after accept.
//  3. B: op 1, a=300, b=-7 -> single alu_bgn pulse in ISSUE; rsp_data=32'hFFFF_F7CC
//     (-2100) after 1+MUL_CYCLES clocks; rsp_borrow=rsp_carry=0.
//  4. Both valid continuously with ops 4 / 6 -> grants alternate A,B,A,B.
//     Holding rsp_ready=0 for 5 clocks freezes rsp_* and keeps req_ready=0.
//  5. A: op 9 -> rsp_err=1, rsp_data=0, alu_bgn never pulses.
//  6. Assert rst during BUSY of a divide (op 0, a=100, b=7) -> no rsp_valid.
//     Re-issue the same divide -> quotient 14, remainder 2 in rsp_data halves.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM encoding, request latch layout.
package alu_pkg;

  localparam logic [3:0] OP_DIV = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  localparam int DEF_DIV_CYCLES = 20;
  localparam int DEF_MUL_CYCLES = 20;
  localparam int DEF_ALU_CYCLES = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Requester, response and ALU-side signals of the scheduler; slave = scheduler side.
interface alu_sched_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_op;
  logic [1:0][15:0] req_a;
  logic [1:0][15:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_data;
  logic             rsp_carry;
  logic             rsp_borrow;
  logic             rsp_err;
  logic             alu_bgn;
  logic [3:0]       alu_control;
  logic [15:0]      alu_nr1;
  logic [15:0]      alu_nr2;
  logic [31:0]      alu_outbus;
  logic             alu_carry;
  logic             alu_borrow;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_outbus, alu_carry, alu_borrow,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_borrow, rsp_err,
           alu_bgn, alu_control, alu_nr1, alu_nr2
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_outbus, alu_carry, alu_borrow,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_borrow, rsp_err,
           alu_bgn, alu_control, alu_nr1, alu_nr2
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; pointer moves to the non-served side on done.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] gnt
);

  logic ptr;  // 0: A has priority on a tie, 1: B

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= 1'b0;
    else if (done) ptr <= ~done_id;
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler for the shared 16-bit ALU: arbitrate, issue, time, respond.
module alu_sched
  import alu_pkg::*;
#(
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int ALU_CYCLES = DEF_ALU_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  alu_sched_if.slave  bus
);

  localparam int CW = $clog2(max3(DIV_CYCLES, MUL_CYCLES, ALU_CYCLES)) + 1;

  state_t        state;
  req_t          cur;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          acc;
  logic          acc_id;
  logic          done;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .done    (done),
    .done_id (cur.id),
    .gnt     (gnt)
  );

  // Grant is only offered in IDLE; gated by rst so nothing is granted while held in reset.
  assign bus.req_ready = (state == IDLE && !rst) ? gnt : 2'b00;
  assign acc           = |(bus.req_valid & bus.req_ready);
  assign acc_id        = bus.req_ready[1];
  assign done          = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cur             <= '0;
      cnt             <= '0;
      bus.alu_bgn     <= 1'b0;
      bus.alu_control <= '0;
      bus.alu_nr1     <= '0;
      bus.alu_nr2     <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_carry   <= 1'b0;
      bus.rsp_borrow  <= 1'b0;
      bus.rsp_err     <= 1'b0;
    end else begin
      bus.alu_bgn <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          cur   <= '{id: acc_id, op: bus.req_op[acc_id], a: bus.req_a[acc_id], b: bus.req_b[acc_id]};
          state <= ISSUE;
          // Illegal opcodes never reach the ALU, so its inputs keep the last real op.
          if (bus.req_op[acc_id] <= OP_XOR) begin
            bus.alu_control <= bus.req_op[acc_id];
            bus.alu_nr1     <= bus.req_a[acc_id];
            bus.alu_nr2     <= bus.req_b[acc_id];
            bus.alu_bgn     <= (bus.req_op[acc_id] <= OP_MUL);
          end
        end
        ISSUE: begin
          if (cur.op > OP_XOR) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= cur.id;
            bus.rsp_data   <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_borrow <= 1'b0;
            bus.rsp_err    <= 1'b1;
            state          <= RESP;
          end else begin
            if (cur.op == OP_DIV)      cnt <= CW'(DIV_CYCLES - 1);
            else if (cur.op == OP_MUL) cnt <= CW'(MUL_CYCLES - 1);
            else                       cnt <= CW'(ALU_CYCLES - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= cur.id;
            bus.rsp_data   <= (cur.op <= OP_MUL) ? bus.alu_outbus : {16'h0000, bus.alu_outbus[15:0]};
            bus.rsp_carry  <= (cur.op == OP_ADD) & bus.alu_carry;
            bus.rsp_borrow <= (cur.op == OP_SUB) & bus.alu_borrow;
            bus.rsp_err    <= 1'b0;
            state          <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU that only presents mul/div results late.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int DIVC = 20;
  localparam int MULC = 20;
  localparam int ALUC = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   bgn_cnt = 0;
  int   lat;

  always #5 clk = ~clk;

  alu_sched_if bus();

  alu_sched #(.DIV_CYCLES(DIVC), .MUL_CYCLES(MULC), .ALU_CYCLES(ALUC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU model: single-cycle ops register every clock with junk in the upper half and
  // junk on the flag the op does not own; mul/div show junk until one cycle before due.
  int k;
  always @(posedge clk or posedge rst) begin
    logic signed [31:0] sa, sb;
    logic [16:0]        s17;
    if (rst) begin
      k <= 0;
      bus.alu_outbus <= '0;
      bus.alu_carry  <= 1'b0;
      bus.alu_borrow <= 1'b0;
    end else begin
      sa = 32'(signed'(bus.alu_nr1));
      sb = 32'(signed'(bus.alu_nr2));
      if (bus.alu_bgn) begin
        k <= 1;
        bus.alu_outbus <= 32'hDEAD_BEEF;
      end else if (k != 0) begin
        if (k == ((bus.alu_control == OP_DIV) ? DIVC : MULC) - 1) begin
          k <= 0;
          if (bus.alu_control == OP_DIV) begin
            logic signed [31:0] q, r;
            q = sa / sb;
            r = sa % sb;
            bus.alu_outbus <= {r[15:0], q[15:0]};
          end else begin
            bus.alu_outbus <= sa * sb;
          end
        end else begin
          k <= k + 1;
          bus.alu_outbus <= 32'hDEAD_BEEF;
        end
      end else if (bus.alu_control >= OP_SUB && bus.alu_control <= OP_XOR) begin
        bus.alu_carry  <= 1'b1;
        bus.alu_borrow <= 1'b1;
        case (bus.alu_control)
          OP_SUB: begin
            s17 = {1'b0, bus.alu_nr1} - {1'b0, bus.alu_nr2};
            bus.alu_outbus <= {16'hA5A5, s17[15:0]};
            bus.alu_borrow <= s17[16];
          end
          OP_ADD: begin
            s17 = {1'b0, bus.alu_nr1} + {1'b0, bus.alu_nr2};
            bus.alu_outbus <= {16'hA5A5, s17[15:0]};
            bus.alu_carry  <= s17[16];
          end
          OP_OR:   bus.alu_outbus <= {16'hA5A5, bus.alu_nr1 | bus.alu_nr2};
          OP_AND:  bus.alu_outbus <= {16'hA5A5, bus.alu_nr1 & bus.alu_nr2};
          default: bus.alu_outbus <= {16'hA5A5, bus.alu_nr1 ^ bus.alu_nr2};
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (bus.alu_bgn) bgn_cnt++;
  endtask

  task automatic wait_gnt(input logic [1:0] exp);
    int w = 0;
    while (bus.req_ready == 2'b00 && w < 50) begin
      tick;
      w++;
    end
    chk("grant", 32'(bus.req_ready), 32'(exp));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick;
      n++;
    end
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int n);
    bus.req_op[id]    = op;
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    bus.req_valid[id] = 1'b1;
    #1;
    wait_gnt(id == 0 ? 2'b01 : 2'b10);
    bgn_cnt = 0;
    tick;
    bus.req_valid[id] = 1'b0;
    wait_rsp(n);
  endtask

  initial begin
    logic [31:0] exp_d;
    int          seen;

    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick;

    // 1: reset state with both requesters valid
    bus.req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_bgn",       32'(bus.alu_bgn), 0);
    chk("rst_ctl",       32'(bus.alu_control), 0);
    chk("rst_rsp_data",  bus.rsp_data, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("first_grant_A", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;

    // 2: add with carry out
    issue(0, OP_ADD, 16'hFFFF, 16'h0001, lat);
    chk("add_lat",    32'(lat), 32'(1 + ALUC));
    chk("add_data",   bus.rsp_data, 32'h0000_0000);
    chk("add_carry",  32'(bus.rsp_carry), 1);
    chk("add_borrow", 32'(bus.rsp_borrow), 0);
    chk("add_id",     32'(bus.rsp_id), 0);
    tick;

    // 3: signed multiply from B
    issue(1, OP_MUL, 16'd300, 16'hFFF9, lat);
    chk("mul_lat",    32'(lat), 32'(1 + MULC));
    chk("mul_bgn",    32'(bgn_cnt), 1);
    chk("mul_data",   bus.rsp_data, 32'hFFFF_F7CC);
    chk("mul_carry",  32'(bus.rsp_carry), 0);
    chk("mul_borrow", 32'(bus.rsp_borrow), 0);
    chk("mul_id",     32'(bus.rsp_id), 1);
    tick;

    // 4: both valid, alternating grants, back-pressure on first response
    bus.req_op[0] = OP_OR;  bus.req_a[0] = 16'h1234; bus.req_b[0] = 16'h0F0F;
    bus.req_op[1] = OP_XOR; bus.req_a[1] = 16'h1234; bus.req_b[1] = 16'h0F0F;
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt((i % 2) ? 2'b10 : 2'b01);
      exp_d = (i % 2) ? 32'h0000_1D3B : 32'h0000_1F3F;
      if (i == 0) bus.rsp_ready = 1'b0;
      tick;
      wait_rsp(lat);
      chk("rr_data", bus.rsp_data, exp_d);
      chk("rr_id",   32'(bus.rsp_id), 32'(i % 2));
      if (i == 0) begin
        repeat (5) begin
          tick;
          chk("hold_valid", 32'(bus.rsp_valid), 1);
          chk("hold_data",  bus.rsp_data, exp_d);
          chk("hold_ready", 32'(bus.req_ready), 0);
        end
        bus.rsp_ready = 1'b1;
      end
      tick;
    end
    bus.req_valid = 2'b00;
    tick;

    // 5: illegal opcode
    issue(0, 4'd9, 16'h0001, 16'h0002, lat);
    chk("err_flag", 32'(bus.rsp_err), 1);
    chk("err_data", bus.rsp_data, 0);
    chk("err_bgn",  32'(bgn_cnt), 0);
    chk("err_lat",  32'(lat), 1);
    tick;

    // 6: reset during a divide, then re-issue
    bus.req_op[0] = OP_DIV; bus.req_a[0] = 16'd100; bus.req_b[0] = 16'd7;
    bus.req_valid[0] = 1'b1;
    #1;
    wait_gnt(2'b01);
    tick;
    bus.req_valid[0] = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus.rsp_valid), 0);
    tick;
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      tick;
      if (bus.rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", 32'(seen), 0);
    issue(0, OP_DIV, 16'd100, 16'd7, lat);
    chk("div_lat",  32'(lat), 32'(1 + DIVC));
    chk("div_bgn",  32'(bgn_cnt), 1);
    chk("div_data", bus.rsp_data, 32'h0002_000E);
    chk("div_err",  32'(bus.rsp_err), 0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
